// File: rtl/multdiv_unit_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
package multdiv_unit_pkg;

    localparam int MD_WIDTH   = 32;
    localparam int MD_ITER    = 32;
    localparam int MD_LATENCY = 33;
    localparam int MD_CNT_W   = 6;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MULT = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } md_op_t;

    typedef enum logic [1:0] {
        BO_NONE = 2'd0,
        BO_ADD  = 2'd1,
        BO_SUB  = 2'd2
    } booth_op_t;

    function automatic booth_op_t booth_recode(input logic q0, input logic qm1);
        booth_op_t op;
        op = BO_NONE;
        unique case ({q0, qm1})
            2'b01:   op = BO_ADD;
            2'b10:   op = BO_SUB;
            default: op = BO_NONE;
        endcase
        return op;
    endfunction

    function automatic logic [MD_WIDTH-1:0] md_abs(input logic [MD_WIDTH-1:0] x);
        return x[MD_WIDTH-1] ? -x : x;
    endfunction

endpackage

// File: rtl/multdiv_unit_if.sv
// Operand, control and result bundle between execute stage and multdiv unit.
interface multdiv_unit_if #(
    parameter int WIDTH = 32
) ();

    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output data_operandA,
        output data_operandB,
        output ctrl_MULT,
        output ctrl_DIV,
        input  data_result,
        input  data_exception,
        input  data_resultRDY,
        input  busy
    );

    modport slave (
        input  data_operandA,
        input  data_operandB,
        input  ctrl_MULT,
        input  ctrl_DIV,
        output data_result,
        output data_exception,
        output data_resultRDY,
        output busy
    );

endinterface

// File: rtl/multdiv_unit_booth_step.sv
// One radix-2 Booth iteration: recode {Q0,Q-1}, add/sub, arithmetic shift.
module booth_step
    import multdiv_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic [2*WIDTH:0] i_prod,
    input  logic             i_qm1,
    input  logic [WIDTH:0]   i_mcand,
    output logic [2*WIDTH:0] o_prod,
    output logic             o_qm1
);

    logic [WIDTH:0] w_acc;
    logic [WIDTH:0] w_sum;
    booth_op_t      w_op;

    assign w_acc = i_prod[2*WIDTH:WIDTH];
    assign w_op  = booth_recode(i_prod[0], i_qm1);

    always_comb begin
        w_sum = w_acc;
        unique case (w_op)
            BO_ADD:  w_sum = w_acc + i_mcand;
            BO_SUB:  w_sum = w_acc - i_mcand;
            default: w_sum = w_acc;
        endcase
    end

    assign o_prod = {w_sum[WIDTH], w_sum, i_prod[WIDTH-1:1]};
    assign o_qm1  = i_prod[0];

endmodule

// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiply (Booth) / divide (restoring) unit, 32 iterations.
module multdiv_unit
    import multdiv_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int ITER  = MD_ITER
) (
    input  logic         clock,
    input  logic         reset,
    multdiv_unit_if.slave bus
);

    md_state_t          r_state;
    md_state_t          w_next;
    md_op_t             r_op;
    logic [MD_CNT_W-1:0] r_cnt;

    logic [2*WIDTH:0]   r_prod;
    logic               r_qm1;
    logic [WIDTH:0]     r_mcand;
    logic [2*WIDTH:0]   w_prod_nx;
    logic               w_qm1_nx;

    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_dvsr;
    logic               r_neg;
    logic               r_dz;
    logic               r_ovf;

    logic [WIDTH-1:0]   r_result;
    logic               r_exc;
    logic               r_rdy;

    logic               w_start;
    logic               w_last;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH+1:0]   w_diff;
    logic               w_ge;
    logic [WIDTH:0]     w_hi;
    logic               w_mul_exc;
    logic [WIDTH-1:0]   w_min;

    assign w_start = bus.ctrl_MULT | bus.ctrl_DIV;
    assign w_last  = (r_cnt == MD_CNT_W'(ITER - 1));
    assign w_min   = {1'b1, {(WIDTH-1){1'b0}}};

    booth_step #(.WIDTH(WIDTH)) u_booth (
        .i_prod  (r_prod),
        .i_qm1   (r_qm1),
        .i_mcand (r_mcand),
        .o_prod  (w_prod_nx),
        .o_qm1   (w_qm1_nx)
    );

    // remainder never reaches 2^WIDTH, so bit WIDTH of a non-negative diff is 0
    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_diff   = {1'b0, w_rem_sh} - {2'b00, r_dvsr};
    assign w_ge     = ~|w_diff[WIDTH+1:WIDTH];

    assign w_hi      = r_prod[2*WIDTH-1:WIDTH-1];
    assign w_mul_exc = ~(&w_hi | ~|w_hi);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (bus.ctrl_MULT) begin
            w_next = MD_MULT;
        end else if (bus.ctrl_DIV) begin
            w_next = MD_DIV;
        end else begin
            unique case (r_state)
                MD_IDLE: w_next = MD_IDLE;
                MD_MULT: w_next = w_last ? MD_DONE : MD_MULT;
                MD_DIV:  w_next = w_last ? MD_DONE : MD_DIV;
                MD_DONE: w_next = MD_IDLE;
                default: w_next = MD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_op     <= OP_MUL;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_qm1    <= 1'b0;
            r_mcand  <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvsr   <= '0;
            r_neg    <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            if (w_start) begin
                r_op    <= bus.ctrl_MULT ? OP_MUL : OP_DIV;
                r_cnt   <= '0;
                r_prod  <= {{(WIDTH+1){1'b0}}, bus.data_operandB};
                r_qm1   <= 1'b0;
                r_mcand <= {bus.data_operandA[WIDTH-1], bus.data_operandA};
                r_quo   <= md_abs(bus.data_operandA);
                r_rem   <= '0;
                r_dvsr  <= md_abs(bus.data_operandB);
                r_neg   <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                r_dz    <= (bus.data_operandB == '0);
                r_ovf   <= (bus.data_operandA == w_min) && (&bus.data_operandB);
            end else begin
                unique case (r_state)
                    MD_MULT: begin
                        r_prod <= w_prod_nx;
                        r_qm1  <= w_qm1_nx;
                        r_cnt  <= r_cnt + 1'b1;
                    end
                    MD_DIV: begin
                        r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], w_ge};
                        r_cnt <= r_cnt + 1'b1;
                    end
                    MD_DONE: begin
                        r_rdy <= 1'b1;
                        if (r_op == OP_MUL) begin
                            r_result <= r_prod[WIDTH-1:0];
                            r_exc    <= w_mul_exc;
                        end else if (r_dz) begin
                            r_result <= '0;
                            r_exc    <= 1'b1;
                        end else begin
                            r_result <= r_neg ? -r_quo : r_quo;
                            r_exc    <= r_ovf;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_exception = r_exc;
    assign bus.data_resultRDY = r_rdy;
    assign bus.busy           = (r_state != MD_IDLE);

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: directed, restart, reset and random ops.
module tb_multdiv_unit;
    import multdiv_unit_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          e0;
    } exp_t;

    logic clk;
    logic rst;
    int   edge_cnt;
    int   n_chk;
    int   n_err;
    exp_t q[$];

    multdiv_unit_if #(.WIDTH(32)) bus ();

    multdiv_unit #(.WIDTH(32), .ITER(32)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic model(input bit m, input logic [31:0] a,
                         input logic [31:0] b,
                         output logic [31:0] r, output logic e);
        logic signed [63:0] p;
        logic        [32:0] hi;
        if (m) begin
            p  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            r  = p[31:0];
            hi = p[63:31];
            e  = !((hi == '0) || (&hi));
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            r = $signed(a) / $signed(b);
            e = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (q.size() > 0 && edge_cnt >= q[0].e0 &&
                edge_cnt < q[0].e0 + MD_LATENCY)
                chk("busy", bus.busy, 1);
            if (bus.data_resultRDY) begin
                if (q.size() == 0) begin
                    chk("unexp_rdy", bus.data_resultRDY, 0);
                end else begin
                    e = q.pop_front();
                    chk("lat", edge_cnt - e.e0, MD_LATENCY);
                    chk("res", bus.data_result, e.res);
                    chk("exc", bus.data_exception, e.exc);
                    chk("busy_rdy", bus.busy, 0);
                end
            end
        end
    end

    // a new start discards whatever was in flight
    task automatic start_op(input bit m, input bit d, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] er,
                            input logic ee);
        exp_t e;
        @(negedge clk);
        #1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        q.delete();
        e.res = er;
        e.exc = ee;
        e.e0  = edge_cnt + 1;
        q.push_back(e);
        @(negedge clk);
        #1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (q.size() > 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            chk("timeout", q.size(), 0);
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [31:0] a, b, r;
        logic        e;
        bit          m;
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_res", bus.data_result, 0);
        chk("rst_exc", bus.data_exception, 0);
        chk("rst_rdy", bus.data_resultRDY, 0);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        start_op(1, 0, 32'd7, 32'd6, 32'd42, 0);                wait_done();
        start_op(1, 0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 0); wait_done();
        start_op(1, 0, 32'h0001_0000, 32'h0001_0000, 32'd0, 1); wait_done();
        start_op(0, 1, 32'd100, 32'd7, 32'd14, 0);              wait_done();
        start_op(0, 1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 0); wait_done();
        start_op(0, 1, 32'd5, 32'd0, 32'd0, 1);                 wait_done();
        start_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        wait_done();

        start_op(1, 0, 32'd3, 32'd3, 32'd9, 0);
        repeat (8) @(negedge clk);
        start_op(0, 1, 32'd9, 32'd2, 32'd4, 0);
        wait_done();
        start_op(1, 1, 32'd8, 32'd2, 32'd16, 0);
        wait_done();

        start_op(1, 0, 32'd123, 32'd456, 32'd56088, 0);
        repeat (14) @(negedge clk);
        #2;
        rst = 1'b1;
        q.delete();
        #1;
        chk("mid_rst_res", bus.data_result, 0);
        chk("mid_rst_exc", bus.data_exception, 0);
        chk("mid_rst_rdy", bus.data_resultRDY, 0);
        chk("mid_rst_busy", bus.busy, 0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (45) @(negedge clk);
        start_op(1, 0, 32'd2, 32'd2, 32'd4, 0);
        wait_done();

        for (int i = 0; i < 10; i++) begin
            m = $urandom_range(0, 1) == 1;
            a = $urandom >> $urandom_range(0, 20);
            if ($urandom_range(0, 1) == 1) a = -a;
            b = (m || $urandom_range(0, 1) == 1) ?
                ($urandom >> $urandom_range(0, 28)) : $urandom_range(0, 20);
            if ($urandom_range(0, 1) == 1) b = -b;
            model(m, a, b, r, e);
            start_op(m, !m, a, b, r, e);
            wait_done();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
